// File: rtl/mlp_layer_sequencer.sv
// Sequencer for one fully-connected layer: streams inputs and weights from
// 1-cycle-latency buffers, accumulates into a bias, then shifts, saturates and applies ReLU.
//
// state | meaning
// IDLE  | waiting for start, configuration latched on acceptance
// BIAS  | issue bias/input/weight addresses for neuron j
// MAC   | N multiply-accumulate cycles for neuron j
// WRITE | write shifted/saturated result of neuron j
// DONE  | one-cycle completion (err flags an invalid configuration)
module mlp_layer_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [12:0] num_inputs,
    input  logic [8:0]  num_outputs,
    input  logic [4:0]  shift,
    input  logic        relu_en,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] input_rd_addr,
    output logic [15:0] weight_rd_addr,
    output logic [7:0]  bias_rd_addr,
    input  logic [7:0]  input_rd_data,
    input  logic [7:0]  weight_rd_data,
    input  logic [7:0]  bias_rd_data,
    output logic [15:0] output_wr_addr,
    output logic [7:0]  output_wr_data,
    output logic        output_wr_en
);

    typedef enum logic [2:0] {S_IDLE, S_BIAS, S_MAC, S_WRITE, S_DONE} state_t;

    state_t             state, state_nxt;
    logic [12:0]        n_q;
    logic [8:0]         m_q;
    logic [4:0]         shift_q;
    logic               relu_q;
    logic               err_q;
    logic [7:0]         j;
    logic [12:0]        k;
    logic [15:0]        wbase;
    logic signed [31:0] acc;

    logic [21:0]        nm_prod;
    logic               cfg_ok;
    logic               last_k;
    logic               last_j;
    logic signed [15:0] x_ext, w_ext, prod;
    logic signed [31:0] prod_ext, bias_ext, acc_sh;
    logic [7:0]         result;

    assign nm_prod = {9'd0, num_inputs} * {13'd0, num_outputs};
    assign cfg_ok  = (num_inputs != 13'd0) && (num_inputs <= 13'd4096) &&
                     (num_outputs != 9'd0) && (num_outputs <= 9'd256) &&
                     (nm_prod <= 22'd16384);
    assign last_k  = (k == n_q - 13'd1);
    assign last_j  = ({1'b0, j} == m_q - 9'd1);

    assign x_ext    = {{8{input_rd_data[7]}}, input_rd_data};
    assign w_ext    = {{8{weight_rd_data[7]}}, weight_rd_data};
    assign prod     = x_ext * w_ext;
    assign prod_ext = {{16{prod[15]}}, prod};
    assign bias_ext = {{24{bias_rd_data[7]}}, bias_rd_data};
    assign acc_sh   = acc >>> shift_q;

    always_comb begin
        result = acc_sh[7:0];
        if (acc_sh > 32'sd127)
            result = 8'h7f;
        else if (acc_sh < -32'sd128)
            result = 8'h80;
        if (relu_q && acc_sh[31])
            result = 8'h00;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = cfg_ok ? S_BIAS : S_DONE;
            S_BIAS:  state_nxt = S_MAC;
            S_MAC:   if (last_k) state_nxt = S_WRITE;
            S_WRITE: state_nxt = last_j ? S_DONE : S_BIAS;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy           = (state != S_IDLE);
        done           = (state == S_DONE);
        err            = (state == S_DONE) && err_q;
        output_wr_en   = (state == S_WRITE);
        output_wr_addr = {8'd0, j};
        output_wr_data = (state == S_WRITE) ? result : 8'd0;
    end

    // Addresses are registered so each state presents them during its own cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_q            <= '0;
            m_q            <= '0;
            shift_q        <= '0;
            relu_q         <= 1'b0;
            err_q          <= 1'b0;
            j              <= '0;
            k              <= '0;
            wbase          <= '0;
            acc            <= '0;
            input_rd_addr  <= '0;
            weight_rd_addr <= '0;
            bias_rd_addr   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        n_q     <= num_inputs;
                        m_q     <= num_outputs;
                        shift_q <= shift;
                        relu_q  <= relu_en;
                        err_q   <= !cfg_ok;
                        j       <= '0;
                        k       <= '0;
                        wbase   <= '0;
                        acc     <= '0;
                        if (cfg_ok) begin
                            input_rd_addr  <= '0;
                            weight_rd_addr <= '0;
                            bias_rd_addr   <= '0;
                        end
                    end
                end
                S_BIAS: begin
                    k              <= '0;
                    input_rd_addr  <= 16'd1;
                    weight_rd_addr <= wbase + 16'd1;
                end
                S_MAC: begin
                    acc <= ((k == 13'd0) ? bias_ext : acc) + prod_ext;
                    if (!last_k) begin
                        k              <= k + 13'd1;
                        input_rd_addr  <= input_rd_addr + 16'd1;
                        weight_rd_addr <= weight_rd_addr + 16'd1;
                    end
                end
                S_WRITE: begin
                    if (!last_j) begin
                        j              <= j + 8'd1;
                        wbase          <= wbase + {3'd0, n_q};
                        input_rd_addr  <= '0;
                        weight_rd_addr <= wbase + {3'd0, n_q};
                        bias_rd_addr   <= j + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Self-checking bench for mlp_layer_sequencer: buffer models with 1-cycle reads and
// a dot-product reference computed directly from the layer definition.
module tb_mlp_layer_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [12:0] num_inputs = '0;
    logic [8:0]  num_outputs = '0;
    logic [4:0]  shift = '0;
    logic        relu_en = 1'b0;
    logic        busy, done, err;
    logic [15:0] input_rd_addr, weight_rd_addr;
    logic [7:0]  bias_rd_addr;
    logic [7:0]  input_rd_data = '0, weight_rd_data = '0, bias_rd_data = '0;
    logic [15:0] output_wr_addr;
    logic [7:0]  output_wr_data;
    logic        output_wr_en;

    logic [7:0]  in_mem [65536];
    logic [7:0]  w_mem  [65536];
    logic [7:0]  b_mem  [256];
    int          exp_out [256];

    int n_checks = 0;
    int n_fail   = 0;

    mlp_layer_sequencer dut (
        .clk(clk), .rst(rst), .start(start),
        .num_inputs(num_inputs), .num_outputs(num_outputs),
        .shift(shift), .relu_en(relu_en),
        .busy(busy), .done(done), .err(err),
        .input_rd_addr(input_rd_addr), .weight_rd_addr(weight_rd_addr),
        .bias_rd_addr(bias_rd_addr),
        .input_rd_data(input_rd_data), .weight_rd_data(weight_rd_data),
        .bias_rd_data(bias_rd_data),
        .output_wr_addr(output_wr_addr), .output_wr_data(output_wr_data),
        .output_wr_en(output_wr_en)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        input_rd_data  <= in_mem[input_rd_addr];
        weight_rd_data <= w_mem[weight_rd_addr];
        bias_rd_data   <= b_mem[bias_rd_addr];
    end

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // y[j] = clamp(floor((bias[j] + sum_k x[k]*w[j*N+k]) / 2^shift)), optional ReLU
    task automatic compute_exp(input int n, input int m, input int sh, input bit relu);
        for (int jj = 0; jj < m; jj++) begin
            longint acc;
            int b;
            b = $signed(b_mem[jj]);
            acc = b;
            for (int kk = 0; kk < n; kk++) begin
                int xv, wv;
                xv = $signed(in_mem[kk]);
                wv = $signed(w_mem[jj*n + kk]);
                acc += xv * wv;
            end
            acc = acc >>> sh;
            if (acc > 127) acc = 127;
            if (acc < -128) acc = -128;
            if (relu && acc < 0) acc = 0;
            exp_out[jj] = int'(acc);
        end
    endtask

    task automatic run_layer(input int n, input int m, input int sh, input bit relu, input int poke);
        bit inv;
        int lat, nwr;
        bit got_done;
        inv = (n == 0 || n > 4096 || m == 0 || m > 256 || n*m > 16384);
        lat = inv ? 1 : m*(n+2) + 1;
        if (!inv) compute_exp(n, m, sh, relu);
        @(negedge clk);
        num_inputs  = n[12:0];
        num_outputs = m[8:0];
        shift       = sh[4:0];
        relu_en     = relu;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start       = 1'b0;
        num_inputs  = 13'($urandom);
        num_outputs = 9'($urandom);
        shift       = 5'($urandom);
        relu_en     = 1'($urandom);
        got_done = 1'b0;
        nwr = 0;
        for (int c = 1; c <= lat + 2 && !got_done; c++) begin
            @(negedge clk);
            start = (c == poke);
            check_val("busy", busy, 1);
            if (done) begin
                got_done = 1'b1;
                check_val("latency", c, lat);
                check_val("err", err, inv);
                check_val("wr_en_in_done", output_wr_en, 0);
            end else if (!inv) begin
                int p, jj, ph;
                p  = c - 1;
                jj = p / (n + 2);
                ph = p % (n + 2);
                if (ph == 0) begin
                    check_val("bias_addr", bias_rd_addr, jj);
                    check_val("weight_addr", weight_rd_addr, jj*n);
                    check_val("input_addr", input_rd_addr, 0);
                end
                if (ph == n + 1) begin
                    nwr++;
                    check_val("wr_en", output_wr_en, 1);
                    check_val("wr_addr", output_wr_addr, jj);
                    check_val("wr_data", $signed(output_wr_data), exp_out[jj]);
                end else begin
                    check_val("wr_en_idle", output_wr_en, 0);
                end
            end else begin
                check_val("wr_en_invalid", output_wr_en, 0);
            end
        end
        start = 1'b0;
        if (!got_done) check_val("done_timeout", 0, 1);
        check_val("write_count", nwr, inv ? 0 : m);
        @(negedge clk);
        check_val("busy_after", busy, 0);
        check_val("done_after", done, 0);
    endtask

    task automatic fill_random();
        for (int i = 0; i < 4096; i++)  in_mem[i] = 8'($urandom);
        for (int i = 0; i < 16384; i++) w_mem[i]  = 8'($urandom);
        for (int i = 0; i < 256; i++)   b_mem[i]  = 8'($urandom);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            in_mem[i] = '0;
            w_mem[i]  = '0;
        end
        for (int i = 0; i < 256; i++) b_mem[i] = '0;

        #2;
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_err", err, 0);
        check_val("rst_wr_en", output_wr_en, 0);
        check_val("rst_in_addr", input_rd_addr, 0);
        check_val("rst_w_addr", weight_rd_addr, 0);
        check_val("rst_wr_data", output_wr_data, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        in_mem[0] = 8'd3; w_mem[0] = 8'd4; b_mem[0] = 8'd5;
        run_layer(1, 1, 0, 0, 0);

        in_mem[0] = 8'd127; in_mem[1] = 8'd127;
        w_mem[0]  = 8'd127; w_mem[1]  = 8'd127; b_mem[0] = 8'd0;
        run_layer(2, 1, 0, 0, 0);
        w_mem[0] = 8'h80; w_mem[1] = 8'h80;
        run_layer(2, 1, 0, 0, 0);
        run_layer(2, 1, 0, 1, 0);

        in_mem[0] = 8'hfd; w_mem[0] = 8'd1;
        run_layer(1, 1, 1, 0, 0);
        in_mem[0] = 8'd5;
        run_layer(1, 1, 1, 0, 0);

        fill_random();
        run_layer(3, 2, 2, 0, 0);
        run_layer(200, 100, 0, 0, 0);
        run_layer(0, 5, 0, 0, 0);
        run_layer(5, 0, 0, 0, 0);
        run_layer(4097, 1, 0, 0, 0);
        run_layer(1, 257, 0, 0, 0);
        run_layer(129, 128, 0, 0, 0);
        run_layer(4096, 4, 9, 0, 0);
        run_layer(64, 256, 7, 1, 0);

        // start pulse while in MAC must not disturb the run
        run_layer(20, 3, 4, 0, 5);

        for (int t = 0; t < 8; t++) begin
            int n, m;
            n = int'($urandom_range(1, 40));
            m = int'($urandom_range(1, 12));
            run_layer(n, m, int'($urandom_range(0, 31)), 1'($urandom),
                      ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, n + 1)) : 0);
        end

        // asynchronous reset in the middle of MAC
        @(negedge clk);
        num_inputs = 13'd20; num_outputs = 9'd3; shift = 5'd2; relu_en = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_val("arst_busy", busy, 0);
        check_val("arst_done", done, 0);
        check_val("arst_err", err, 0);
        check_val("arst_wr_en", output_wr_en, 0);
        check_val("arst_in_addr", input_rd_addr, 0);
        check_val("arst_w_addr", weight_rd_addr, 0);
        check_val("arst_b_addr", bias_rd_addr, 0);
        check_val("arst_wr_addr", output_wr_addr, 0);
        check_val("arst_wr_data", output_wr_data, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("arst_hold_wr_en", output_wr_en, 0);
        end
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            check_val("post_rst_idle_wr_en", output_wr_en, 0);
            check_val("post_rst_idle_busy", busy, 0);
        end
        run_layer(20, 3, 2, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
